// File: rtl/gpo_cond_pkg.sv
// rtl/gpo_cond_pkg.sv - shared defaults for the RFIC GPO input conditioner
package gpo_cond_pkg;

  localparam int DEF_NUM_LINES   = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_W      = 8;
  localparam int DEF_STRETCH_W   = 16;

  // GPO lines contributed by each AD9361
  localparam int RFIC_LINES = 4;

endpackage

// File: rtl/gpo_cond_line.sv
// rtl/gpo_cond_line.sv - one GPO line: sync, glitch filter, invert, edge detect, stretch, sticky flags
module gpo_cond_line
  import gpo_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int STRETCH_W   = DEF_STRETCH_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 raw_in,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic                 invert,
  input  logic                 clear_events,
  output logic                 line_out,
  output logic                 rise_event,
  output logic                 fall_event
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   f_q, f_d;
  logic [FILT_W-1:0]      c_q, c_d;
  logic                   prev_q, prev_d;
  logic [STRETCH_W-1:0]   s_q, s_d;
  logic                   out_q, out_d;
  logic                   rise_ev_q, rise_ev_d;
  logic                   fall_ev_q, fall_ev_d;
  logic                   synced, lvl, rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    synced = sync_q[SYNC_STAGES-1];

    f_d = f_q;
    c_d = c_q;
    // >= rather than == so a lowered filt_len takes effect mid-count
    if (synced == f_q) begin
      c_d = '0;
    end else if (c_q >= filt_len) begin
      f_d = ~f_q;
      c_d = '0;
    end else begin
      c_d = c_q + 1'b1;
    end

    lvl    = f_q ^ invert;
    rise   = lvl & ~prev_q;
    fall   = ~lvl & prev_q;
    prev_d = lvl;

    s_d = s_q;
    if (rise && (stretch_len != '0)) begin
      s_d = stretch_len - 1'b1;
    end else if (s_q != '0) begin
      s_d = s_q - 1'b1;
    end
    out_d = lvl | (s_q != '0);

    // a same-cycle edge beats the software clear
    rise_ev_d = rise | (rise_ev_q & ~clear_events);
    fall_ev_d = fall | (fall_ev_q & ~clear_events);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      f_q       <= 1'b0;
      c_q       <= '0;
      prev_q    <= 1'b0;
      s_q       <= '0;
      out_q     <= 1'b0;
      rise_ev_q <= 1'b0;
      fall_ev_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      f_q       <= f_d;
      c_q       <= c_d;
      prev_q    <= prev_d;
      s_q       <= s_d;
      out_q     <= out_d;
      rise_ev_q <= rise_ev_d;
      fall_ev_q <= fall_ev_d;
    end
  end

  assign line_out   = out_q;
  assign rise_event = rise_ev_q;
  assign fall_event = fall_ev_q;

endmodule

// File: rtl/gpo_input_conditioner.sv
// rtl/gpo_input_conditioner.sv - conditions both RFICs' GPO lines ahead of the GPO line matrix
module gpo_input_conditioner
  import gpo_cond_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int STRETCH_W   = DEF_STRETCH_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_LINES-1:0] raw_in,
  input  logic [FILT_W-1:0]    filt_len,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic [NUM_LINES-1:0] invert,
  input  logic [NUM_LINES-1:0] clear_events,
  output logic [NUM_LINES-1:0] lines_out,
  output logic [NUM_LINES-1:0] rise_event,
  output logic [NUM_LINES-1:0] fall_event
);

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    gpo_cond_line #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .STRETCH_W   (STRETCH_W)
    ) u_line (
      .clk          (clk),
      .rstn         (rstn),
      .raw_in       (raw_in[i]),
      .filt_len     (filt_len),
      .stretch_len  (stretch_len),
      .invert       (invert[i]),
      .clear_events (clear_events[i]),
      .line_out     (lines_out[i]),
      .rise_event   (rise_event[i]),
      .fall_event   (fall_event[i])
    );
  end

endmodule

// File: tb/tb_gpo_input_conditioner.sv
// tb/tb_gpo_input_conditioner.sv - directed self-checking bench for gpo_input_conditioner
module tb_gpo_input_conditioner;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  raw_in;
  logic [7:0]  filt_len;
  logic [15:0] stretch_len;
  logic [7:0]  invert;
  logic [7:0]  clear_events;
  logic [7:0]  lines_out;
  logic [7:0]  rise_event;
  logic [7:0]  fall_event;

  int tests_run    = 0;
  int tests_failed = 0;
  int hi_cnt;
  logic [7:0] acc;

  gpo_input_conditioner dut (
    .clk          (clk),
    .rstn         (rstn),
    .raw_in       (raw_in),
    .filt_len     (filt_len),
    .stretch_len  (stretch_len),
    .invert       (invert),
    .clear_events (clear_events),
    .lines_out    (lines_out),
    .rise_event   (rise_event),
    .fall_event   (fall_event)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    clear_events = 8'hff;
    step();
    clear_events = 8'h00;
  endtask

  initial begin
    rstn = 1'b0; raw_in = 8'h00; filt_len = 8'd0; stretch_len = 16'd0;
    invert = 8'h00; clear_events = 8'h00;

    // reset state
    repeat (3) step();
    chk("rst_lines", 32'(lines_out), 32'h00);
    chk("rst_rise", 32'(rise_event), 32'h00);
    chk("rst_fall", 32'(fall_event), 32'h00);
    invert = 8'h01;
    step();
    chk("rst_inv_held", 32'(lines_out), 32'h00);

    // invert out of reset gives an immediate rise on line 0
    rstn = 1'b1;
    step();
    chk("inv_rise_ev", 32'(rise_event), 32'h01);
    chk("inv_lines", 32'(lines_out), 32'h01);
    chk("inv_no_fall", 32'(fall_event), 32'h00);
    invert = 8'h00;
    step();
    chk("uninv_lines", 32'(lines_out), 32'h00);
    chk("uninv_fall_ev", 32'(fall_event), 32'h01);
    clear_all();
    chk("clr_rise", 32'(rise_event), 32'h00);
    chk("clr_fall", 32'(fall_event), 32'h00);

    // glitch filter L=3: 3-cycle pulse rejected, 4-cycle accepted at latency 7
    filt_len = 8'd3; stretch_len = 16'd0;
    raw_in[2] = 1'b1;
    acc = 8'h00;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 2) raw_in[2] = 1'b0;
      acc = acc | lines_out | rise_event | fall_event;
    end
    chk("filt_reject", 32'(acc), 32'h00);
    raw_in[2] = 1'b1;
    repeat (6) step();
    chk("filt_lat6", 32'(lines_out[2]), 32'h0);
    step();
    chk("filt_lat7", 32'(lines_out[2]), 32'h1);
    chk("filt_rise_ev", 32'(rise_event), 32'h04);
    raw_in[2] = 1'b0;
    repeat (10) step();
    chk("filt_fall", 32'(lines_out), 32'h00);
    clear_all();

    // stretch S=10, single 1-cycle pulse
    filt_len = 8'd0; stretch_len = 16'd10;
    hi_cnt = 0;
    raw_in[5] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 0) raw_in[5] = 1'b0;
      if (lines_out[5]) hi_cnt++;
    end
    chk("stretch_width", 32'(hi_cnt), 32'd10);

    // retrigger 4 cycles after the first pulse
    hi_cnt = 0;
    raw_in[5] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) raw_in[5] = 1'b0;
      if (i == 3) raw_in[5] = 1'b1;
      if (i == 4) raw_in[5] = 1'b0;
      if (lines_out[5]) hi_cnt++;
    end
    chk("retrig_width", 32'(hi_cnt), 32'd14);
    clear_all();

    // sticky events on line 1 with L=0, S=0
    stretch_len = 16'd0;
    raw_in[1] = 1'b1;
    repeat (6) step();
    chk("ev1_rise", 32'(rise_event), 32'h02);
    chk("ev1_nofall", 32'(fall_event), 32'h00);
    raw_in[1] = 1'b0;
    repeat (6) step();
    chk("ev1_fall", 32'(fall_event), 32'h02);
    raw_in[1] = 1'b1;
    repeat (3) step();
    clear_events = 8'h02;
    step();
    clear_events = 8'h00;
    chk("ev1_set_wins", 32'(rise_event), 32'h02);
    repeat (3) step();
    clear_events = 8'h02;
    step();
    clear_events = 8'h00;
    chk("ev1_idle_clr_r", 32'(rise_event), 32'h00);
    chk("ev1_idle_clr_f", 32'(fall_event), 32'h00);
    raw_in[1] = 1'b0;
    repeat (6) step();
    clear_all();

    // lowering filt_len mid-count on line 3
    filt_len = 8'd200;
    raw_in[3] = 1'b1;
    repeat (52) step();
    chk("lowL_c50", 32'(lines_out[3]), 32'h0);
    filt_len = 8'd5;
    step();
    chk("lowL_toggle_cyc", 32'(lines_out[3]), 32'h0);
    step();
    chk("lowL_out", 32'(lines_out[3]), 32'h1);
    raw_in[3] = 1'b0;
    repeat (12) step();
    chk("lowL_fall", 32'(lines_out), 32'h00);
    clear_all();

    // reset in the middle of a stretch (s = 7)
    filt_len = 8'd0; stretch_len = 16'd10;
    raw_in[5] = 1'b1;
    step();
    raw_in[5] = 1'b0;
    repeat (5) step();
    chk("mid_stretch_hi", 32'(lines_out[5]), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_out", 32'(lines_out), 32'h00);
    chk("async_rst_ev", 32'(rise_event), 32'h00);
    repeat (2) step();
    rstn = 1'b1;
    acc = 8'h00;
    for (int i = 0; i < 12; i++) begin
      step();
      acc = acc | lines_out;
    end
    chk("no_residual", 32'(acc), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
